// File: rtl/dreg_arb_pkg.sv
// Shared types and helpers for the round-robin data-register arbiter.
// Holds the FSM state encoding, index-width helper and reset constants.
package dreg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ACK
    } state_t;

    function automatic int idxw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // last_owner resets to the top index so requester 0 is searched first
    function automatic int last_owner_rst(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/dreg_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above start,
// wrapping upward; returns the one-hot winner and its index.
module rr_pick
    import dreg_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDXW  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDXW-1:0]  start,
    output logic [N_REQ-1:0] onehot,
    output logic [IDXW-1:0]  idx
);

    always_comb begin
        int unsigned pos;
        logic        found;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = int'(start) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (!found && req[pos]) begin
                found       = 1'b1;
                onehot[pos] = 1'b1;
                idx         = IDXW'(pos);
            end
        end
    end

endmodule

// File: rtl/dreg_rr_arbiter.sv
// Round-robin arbiter and sequencer for a single shared data register.
// One transfer per IDLE -> GRANT -> ACK pass; grant, capture and ack are registered.
module dreg_rr_arbiter
    import dreg_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   wdata,
    input  logic                     clr,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         ack,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic [$clog2(N_REQ)-1:0] owner
);

    localparam int IDXW = idxw(N_REQ);
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(last_owner_rst(N_REQ));

    state_t            state, state_d;
    logic [N_REQ-1:0]  gnt_d, ack_d, pick_oh;
    logic [WIDTH-1:0]  q_d, lane;
    logic              q_valid_d;
    logic [IDXW-1:0]   owner_d, last_owner, last_d, win_idx, win_d, start, pick_idx;

    assign start = (last_owner == IDXW'(N_REQ - 1)) ? '0 : last_owner + 1'b1;
    assign lane  = wdata[win_idx*WIDTH +: WIDTH];

    rr_pick #(
        .N_REQ (N_REQ),
        .IDXW  (IDXW)
    ) u_pick (
        .req    (req),
        .start  (start),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            ack        <= '0;
            q          <= '0;
            q_valid    <= 1'b0;
            owner      <= '0;
            last_owner <= LAST_RST;
            win_idx    <= '0;
        end else begin
            state      <= state_d;
            gnt        <= gnt_d;
            ack        <= ack_d;
            q          <= q_d;
            q_valid    <= q_valid_d;
            owner      <= owner_d;
            last_owner <= last_d;
            win_idx    <= win_d;
        end
    end

    // clr applies in every state; a capture in GRANT overrides it
    always_comb begin
        state_d   = state;
        gnt_d     = gnt;
        ack_d     = ack;
        q_d       = q;
        q_valid_d = clr ? 1'b0 : q_valid;
        owner_d   = owner;
        last_d    = last_owner;
        win_d     = win_idx;
        case (state)
            IDLE: begin
                gnt_d = '0;
                ack_d = '0;
                if (|req) begin
                    gnt_d   = pick_oh;
                    win_d   = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                q_d       = lane;
                q_valid_d = 1'b1;
                owner_d   = win_idx;
                last_d    = win_idx;
                ack_d     = gnt;
                gnt_d     = '0;
                state_d   = ACK;
            end
            ACK: begin
                ack_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                ack_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule
